// File: rtl/pixel_compositor_pkg.sv
// Shared constants and types for the sprite-ROM pixel compositor:
// layer/address geometry, transparency key, pixel-divider sequencing and colour split.
package pixel_compositor_pkg;

    localparam int          NUM_LAYERS = 4;
    localparam int          ADDR_W     = 17;
    localparam logic [11:0] KEY_COLOR  = 12'h0F0;

    localparam int PIX_DIV  = 4;
    localparam int LATENCY  = 6;
    localparam int MAX_HITS = 3;
    localparam int NUM_CAND = MAX_HITS + 1;

    localparam int COLOR_W = 12;
    localparam int CH_W    = 4;
    localparam int R_LSB   = 8;
    localparam int G_LSB   = 4;
    localparam int B_LSB   = 0;

    typedef logic [COLOR_W-1:0] color_t;

    localparam int PHASE_W = $clog2(PIX_DIV);
    typedef logic [PHASE_W-1:0] phase_t;
    localparam phase_t PHASE_LAST = phase_t'(PIX_DIV - 1);

endpackage

// File: rtl/pixel_compositor_cand_select.sv
// Combinational priority picker: returns the indices of the first NUM_HITS set
// bits of obj_hit in ascending order, each with a valid flag.
module cand_select #(
    parameter int NUM_LAYERS = 4,
    parameter int NUM_HITS   = 3,
    parameter int IDX_W      = 2
) (
    input  logic [NUM_LAYERS-1:0]          obj_hit,
    output logic [NUM_HITS-1:0][IDX_W-1:0] hit_idx,
    output logic [NUM_HITS-1:0]            hit_vld
);

    localparam int CNT_W = $clog2(NUM_HITS + 1);

    logic [CNT_W-1:0] n;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the tool infers a latch.
    always_comb begin
        hit_idx = '0;
        hit_vld = '0;
        n       = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (obj_hit[i] && (n < CNT_W'(NUM_HITS))) begin
                hit_idx[n] = IDX_W'(i);
                hit_vld[n] = 1'b1;
                n          = n + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_compositor.sv
// Collects per-layer sprite requests, reads the shared sprite ROM over four
// cycles per pixel, resolves priority/colour key and drives registered VGA outputs.
module pixel_compositor #(
    parameter int          NUM_LAYERS = pixel_compositor_pkg::NUM_LAYERS,
    parameter int          ADDR_W     = pixel_compositor_pkg::ADDR_W,
    parameter logic [11:0] KEY_COLOR  = pixel_compositor_pkg::KEY_COLOR
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pclk_en,
    input  logic                         in_active,
    input  logic                         in_hsync,
    input  logic                         in_vsync,
    input  logic [NUM_LAYERS-1:0]        obj_hit,
    input  logic [NUM_LAYERS*ADDR_W-1:0] obj_addr,
    input  logic [ADDR_W-1:0]            bg_addr,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [11:0]                  rom_data,
    output logic [3:0]                   vga_r,
    output logic [3:0]                   vga_g,
    output logic [3:0]                   vga_b,
    output logic                         hsync,
    output logic                         vsync
);
    import pixel_compositor_pkg::*;

    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    logic [MAX_HITS-1:0][IDX_W-1:0] hit_idx;
    logic [MAX_HITS-1:0]            hit_vld;

    cand_select #(
        .NUM_LAYERS(NUM_LAYERS),
        .NUM_HITS  (MAX_HITS),
        .IDX_W     (IDX_W)
    ) u_cand_select (
        .obj_hit(obj_hit),
        .hit_idx(hit_idx),
        .hit_vld(hit_vld)
    );

    // Candidate list: first hits in priority order, background fills the rest.
    logic [NUM_CAND-1:0][ADDR_W-1:0] cand_addr;
    logic [NUM_CAND-1:0]             cand_layer;

    always_comb begin
        for (int k = 0; k < NUM_CAND; k++) begin
            cand_addr[k]  = bg_addr;
            cand_layer[k] = 1'b0;
        end
        for (int k = 0; k < MAX_HITS; k++) begin
            cand_layer[k] = hit_vld[k];
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (hit_vld[k] && (hit_idx[k] == IDX_W'(i)))
                    cand_addr[k] = obj_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    logic [NUM_CAND-1:1][ADDR_W-1:0] s_addr;
    logic [NUM_CAND-1:0]             s_layer;
    logic                            s_active, s_hsync, s_vsync;
    logic                            out_active, out_hsync, out_vsync;

    phase_t phase;
    phase_t rd_k;
    logic   in_flight;
    logic   rd_valid;
    logic   rd_layer;
    logic   found;
    color_t winner;
    color_t color_q;

    // NOTE: data-only registers carry no reset; the control flags that
    // qualify them are reset, so their power-up contents are never observed.
    always_ff @(posedge clk) begin
        if (pclk_en) begin
            s_addr   <= cand_addr[NUM_CAND-1:1];
            s_layer  <= cand_layer;
            s_active <= in_active;
            s_hsync  <= in_hsync;
            s_vsync  <= in_vsync;
        end
        // Hand the pixel's flags to the output stage before a new sample can overwrite them.
        if (in_flight && (phase == PHASE_LAST)) begin
            out_active <= s_active;
            out_hsync  <= s_hsync;
            out_vsync  <= s_vsync;
        end
    end

    logic   found_cur, found_nxt;
    color_t win_nxt;

    always_comb begin
        found_cur = found && (rd_k != '0);
        found_nxt = found_cur;
        win_nxt   = winner;
        if (!found_cur && (!rd_layer || (rom_data != KEY_COLOR))) begin
            found_nxt = 1'b1;
            win_nxt   = rom_data;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase     <= '0;
            in_flight <= 1'b0;
            rd_valid  <= 1'b0;
            rd_k      <= '0;
            rd_layer  <= 1'b0;
            found     <= 1'b0;
            winner    <= '0;
            rom_addr  <= '0;
            color_q   <= '0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
        end else begin
            if (pclk_en)
                phase <= '0;
            else if (phase != PHASE_LAST)
                phase <= phase + 1'b1;

            if (pclk_en)
                in_flight <= 1'b1;
            else if (phase == PHASE_LAST)
                in_flight <= 1'b0;

            rd_valid <= in_flight;
            rd_k     <= phase;
            rd_layer <= s_layer[phase];

            if (pclk_en)
                rom_addr <= cand_addr[0];
            else if (in_flight && (phase != PHASE_LAST))
                rom_addr <= s_addr[phase + 1'b1];

            if (rd_valid) begin
                found  <= found_nxt;
                winner <= win_nxt;
            end

            // Slot 3 is always background, so the winner is settled here.
            if (rd_valid && (rd_k == PHASE_LAST)) begin
                color_q <= out_active ? win_nxt : '0;
                hsync   <= out_hsync;
                vsync   <= out_vsync;
            end
        end
    end

    assign vga_r = color_q[R_LSB +: CH_W];
    assign vga_g = color_q[G_LSB +: CH_W];
    assign vga_b = color_q[B_LSB +: CH_W];

endmodule
